ibex_multdiv_iter: RTL and testbench
====================================

Name: ibex_multdiv_iter

Overview:
Parametrised iterative multiply/divide unit for the execution stage. It generalises the fixed 32-bit multdiv paths to a configurable operand width and multiplier radix. It uses its own valid/ready handshakes and holds its intermediate state internally, so no external intermediate-value register is needed. An abort input cancels the operation in flight. The ex block instantiates it and muxes its result against the ALU result.

Parameters:
Width, 32, operand/result width in bits; must be even and ≥ 8.
MulBitsPerCycle, 2, multiplier bits retired per MUL cycle; must be 1, 2 or 4 and divide Width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  reset, synchronous, active-low
in_valid_i  in  1  operation request
in_ready_o  out  1  unit can accept a request (high only in IDLE)
op_i  in  2  00 MULL, 01 MULH, 10 DIV, 11 REM
signed_mode_i  in  2  bit0 = operand a signed, bit1 = operand b signed
op_a_i  in  Width  operand a / dividend
op_b_i  in  Width  operand b / divisor
data_ind_timing_i  in  1  1 = force fixed latency (sampled at accept)
kill_i  in  1  abort the current operation
out_valid_o  out  1  result available
out_ready_i  in  1  consumer takes the result
result_o  out  Width  result, held stable while out_valid_o=1

Behaviour:
- Reset (rst_ni=0 at a clock edge) has priority over all other inputs. State goes to IDLE. in_ready_o=0 during the reset cycle and 1 afterwards. out_valid_o=0, result_o=0, and all internal registers are cleared.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept: in IDLE, in_valid_i & in_ready_o registers op, signed mode, |a|, |b|, sign flags and data_ind_timing_i.
- After accept, the state goes to MUL (op_i[1]=0) or DIV (op_i[1]=1).
- Operand magnitudes: a signed operand with its MSB set is negated; all other operands are zero-extended.
- MUL state:
  - Shift-add on the 2·Width-bit accumulator, MulBitsPerCycle bits of |b| per cycle.
  - Runs Width/MulBitsPerCycle cycles, then goes to FIX.
- DIV state:
  - Radix-2 restoring division, one quotient bit per cycle, Width cycles, then goes to FIX.
  - Quotient and remainder are held in a 2·Width-bit shift register.
- FIX state (1 cycle):
  - Negates the product when sign(a) xor sign(b), counting only signed operands.
  - Negates the quotient when signs differ; the remainder takes the sign of the dividend.
  - Selects the output: MULL = product[Width-1:0], MULH = product[2W-1:W], DIV = quotient, REM = remainder.
  - Goes to DONE.
- DONE state:
  - out_valid_o=1 with result_o stable.
  - On out_ready_i=1, goes to IDLE; in_ready_o rises the following cycle (no back-to-back accept in the DONE cycle).
- Latency, counted from the accept edge as cycle 0, to the first cycle of out_valid_o:
  - MUL: Width/MulBitsPerCycle + 2; 18 for W=32, step 2.
  - DIV: Width + 2; 34 for W=32.
- Divide by zero (RISC-V semantics): quotient = all ones, remainder = dividend.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value, remainder = 0.
- Both special cases come out of the normal iteration naturally or are forced in FIX. They never change latency unless the optional feature is enabled.
- kill_i:
  - In MUL/DIV/FIX: next state is IDLE and out_valid_o is never asserted for that operation.
  - In DONE: the result is dropped and the state goes to IDLE.
  - In IDLE: kill_i takes precedence over in_valid_i; no accept occurs.
- in_valid_i while busy is ignored. The requester must hold its request until in_ready_o=1.
- The iteration counter is sized for $clog2(Width)+1 bits and never wraps within an operation.

Optional Feature:
Macro: IBEX_MULTDIV_ITER_EARLY_OUT_EN.
- Defined, and the sampled data_ind_timing_i=0:
  - Divide by zero goes directly from accept to FIX, so out_valid_o arrives at cycle 2.
  - MUL with |a|=0 or |b|=0 goes directly to FIX, so out_valid_o arrives at cycle 2.
- Defined with data_ind_timing_i=1, or macro undefined: latency is always as stated in Behaviour.

Test Plan:
- W=32, step 2: MULL, signed_mode=11, a=−3 (0xFFFFFFFD), b=7 -> out_valid_o at cycle 18, result 0xFFFFFFEB.
- MULH, signed_mode=00, a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE at cycle 18.
- MULH, signed_mode=01 (a signed, b unsigned), a=0xFFFFFFFF (−1), b=2 -> result 0xFFFFFFFF.
- DIV and REM signed, a=−7, b=2 -> quotient 0xFFFFFFFD (−3) and remainder 0xFFFFFFFF (−1), each at cycle 34.
- DIV, b=0, a=0x1234:
  - quotient 0xFFFFFFFF; REM gives 0x1234.
  - Macro on, data_ind_timing_i=0: valid at cycle 2.
  - Macro on, data_ind_timing_i=1: valid at cycle 34.
- Signed DIV, a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000; REM gives 0.
- Start a DIV, pulse kill_i at cycle 10 -> out_valid_o never asserted and in_ready_o=1 at cycle 12.
- Hold out_ready_i=0 for 5 cycles in DONE -> result_o stable.
- Drive rst_ni=0 mid-MUL -> out_valid_o=0 and result_o=0 after that edge, and the next request completes correctly.

Source files
------------

// File: rtl/ibex_multdiv_iter.sv
// rtl/ibex_multdiv_iter.sv - iterative multiply/divide unit with valid/ready handshakes
// Optional early-out on zero operands: IBEX_MULTDIV_ITER_EARLY_OUT_EN
module ibex_multdiv_iter #(
  parameter int unsigned Width           = 32,
  parameter int unsigned MulBitsPerCycle = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Width) + 1;
  localparam int unsigned PpW  = Width + MulBitsPerCycle;
  localparam logic [CntW-1:0] MulCycles = CntW'(Width / MulBitsPerCycle);
  localparam logic [CntW-1:0] DivCycles = CntW'(Width);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [Width-1:0]     r_result;
  logic [1:0]           r_op;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic [Width-1:0]     r_mag_a;
  logic [Width-1:0]     r_mag_b;
  logic [2*Width-1:0]   r_acc;
  logic [CntW-1:0]      r_cnt;

  logic                 w_accept;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [Width-1:0]     w_mag_a;
  logic [Width-1:0]     w_mag_b;
  logic                 w_early;

  assign w_accept = in_valid_i & r_in_ready & ~kill_i;
  assign w_neg_a  = signed_mode_i[0] & op_a_i[Width-1];
  assign w_neg_b  = signed_mode_i[1] & op_b_i[Width-1];
  assign w_mag_a  = w_neg_a ? -op_a_i : op_a_i;
  assign w_mag_b  = w_neg_b ? -op_b_i : op_b_i;

`ifdef IBEX_MULTDIV_ITER_EARLY_OUT_EN
  assign w_early = ~data_ind_timing_i &
                   (op_i[1] ? (w_mag_b == '0) : ((w_mag_a == '0) || (w_mag_b == '0)));
`else
  logic w_unused_dit;
  assign w_unused_dit = data_ind_timing_i;
  assign w_early      = 1'b0;
`endif

  // Multiply: product high half in r_acc[2W-1:W], remaining multiplier bits below it.
  logic [PpW-1:0]       w_pp;
  logic [PpW-1:0]       w_mul_sum;
  logic [2*Width-1:0]   w_mul_next;

  assign w_pp       = PpW'(r_mag_a) * PpW'(r_acc[MulBitsPerCycle-1:0]);
  assign w_mul_sum  = PpW'(r_acc[2*Width-1:Width]) + w_pp;
  assign w_mul_next = {w_mul_sum, r_acc[Width-1:MulBitsPerCycle]};

  // Divide: partial remainder in the high half, dividend/quotient bits in the low half.
  logic [Width:0]       w_rem_sh;
  logic [Width:0]       w_diff;
  logic [2*Width-1:0]   w_div_next;

  assign w_rem_sh   = r_acc[2*Width-1:Width-1];
  assign w_diff     = w_rem_sh - {1'b0, r_mag_b};
  assign w_div_next = w_diff[Width] ? {r_acc[2*Width-2:0], 1'b0}
                                    : {w_diff[Width-1:0], r_acc[Width-2:0], 1'b1};

  logic                 w_neg_res;
  logic                 w_b_zero;
  logic [2*Width-1:0]   w_prod;
  logic [Width-1:0]     w_q_mag;
  logic [Width-1:0]     w_quot;
  logic [Width-1:0]     w_rem_mag;
  logic [Width-1:0]     w_rem;
  logic [Width-1:0]     w_fix_result;

  assign w_neg_res = r_neg_a ^ r_neg_b;
  assign w_b_zero  = (r_mag_b == '0);
  assign w_prod    = w_neg_res ? -r_acc : r_acc;
  assign w_q_mag   = r_acc[Width-1:0];
  // Divide-by-zero is forced here so signed and early-out cases agree with RISC-V.
  assign w_quot    = w_b_zero ? '1 : (w_neg_res ? -w_q_mag : w_q_mag);
  assign w_rem_mag = w_b_zero ? r_mag_a : r_acc[2*Width-1:Width];
  assign w_rem     = r_neg_a ? -w_rem_mag : w_rem_mag;

  always_comb begin
    w_fix_result = '0;
    case (r_op)
      2'b00:   w_fix_result = w_prod[Width-1:0];
      2'b01:   w_fix_result = w_prod[2*Width-1:Width];
      2'b10:   w_fix_result = w_quot;
      default: w_fix_result = w_rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_op        <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_op       <= op_i;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_mag_a    <= w_mag_a;
            r_mag_b    <= w_mag_b;
            if (op_i[1]) begin
              r_acc   <= {{Width{1'b0}}, w_mag_a};
              r_cnt   <= DivCycles;
            end else begin
              r_acc   <= w_early ? '0 : {{Width{1'b0}}, w_mag_b};
              r_cnt   <= MulCycles;
            end
            if (w_early) begin
              r_state <= S_FIX;
            end else if (op_i[1]) begin
              r_state <= S_DIV;
            end else begin
              r_state <= S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (kill_i) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (kill_i) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_result    <= w_fix_result;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (kill_i || out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// tb/tb_ibex_multdiv_iter.sv - directed-vector bench for ibex_multdiv_iter (W=32, step 2)
module tb_ibex_multdiv_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [1:0]  smode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        dit;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_vec;
  int n_err;

  ibex_multdiv_iter dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .op_i              (op),
    .signed_mode_i     (smode),
    .op_a_i            (op_a),
    .op_b_i            (op_b),
    .data_ind_timing_i (dit),
    .kill_i            (kill),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .result_o          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for in_ready, then presents one request; returns at mid-cycle 1.
  task automatic issue(input logic [1:0] o, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic d);
    int w;
    w = 0;
    while (!in_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    op       = o;
    smode    = sm;
    op_a     = a;
    op_b     = b;
    dit      = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Returns the cycle in which out_valid first appears (-1 on timeout) and the result then.
  task automatic wait_valid(output logic [31:0] res, output int lat);
    res = '0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (out_valid) begin
        lat = c;
        res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_vec++;
    if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 00000000", result); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int          lat;
    issue(2'b00, 2'b11, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mull_signed got %h want ffffffeb", res); end
    n_vec++;
    if (lat != 18) begin n_err++; $display("FAIL mull_latency got %0d want 18", lat); end

    issue(2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulh_unsigned got %h want fffffffe", res); end
    n_vec++;
    if (lat != 18) begin n_err++; $display("FAIL mulh_latency got %0d want 18", lat); end

    issue(2'b01, 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulh_su got %h want ffffffff", res); end

    issue(2'b00, 2'b00, 32'h0001_0003, 32'h0000_0100, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'h0100_0300) begin n_err++; $display("FAIL mull_unsigned got %h want 01000300", res); end
  endtask

  task automatic test_div();
    logic [31:0] res;
    int          lat;
    issue(2'b10, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_signed got %h want fffffffd", res); end
    n_vec++;
    if (lat != 34) begin n_err++; $display("FAIL div_latency got %0d want 34", lat); end

    issue(2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_signed got %h want ffffffff", res); end
    n_vec++;
    if (lat != 34) begin n_err++; $display("FAIL rem_latency got %0d want 34", lat); end

    issue(2'b10, 2'b00, 32'd100, 32'd7, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'd14) begin n_err++; $display("FAIL divu got %h want 0000000e", res); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    int          lat;
    int          exp_lat;
`ifdef IBEX_MULTDIV_ITER_EARLY_OUT_EN
    exp_lat = 2;
`else
    exp_lat = 34;
`endif
    issue(2'b10, 2'b00, 32'h0000_1234, 32'h0, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_quot got %h want ffffffff", res); end
    n_vec++;
    if (lat != exp_lat) begin n_err++; $display("FAIL div0_latency got %0d want %0d", lat, exp_lat); end

    issue(2'b11, 2'b00, 32'h0000_1234, 32'h0, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'h0000_1234) begin n_err++; $display("FAIL div0_rem got %h want 00001234", res); end

    issue(2'b10, 2'b00, 32'h0000_1234, 32'h0, 1'b1);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (lat != 34) begin n_err++; $display("FAIL div0_fixed_latency got %0d want 34", lat); end

    issue(2'b10, 2'b11, 32'hFFFF_FFF9, 32'h0, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_signed got %h want ffffffff", res); end
  endtask

  task automatic test_overflow();
    logic [31:0] res;
    int          lat;
    issue(2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_quot got %h want 80000000", res); end

    issue(2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'h0) begin n_err++; $display("FAIL ovf_rem got %h want 00000000", res); end
  endtask

  task automatic test_kill();
    logic seen;
    seen = 1'b0;
    issue(2'b10, 2'b00, 32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) kill = 1'b1;
      if (c == 11) kill = 1'b0;
      if (out_valid) seen = 1'b1;
      if (c == 12) begin
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL kill_in_ready got %0b want 1", in_ready); end
      end
      @(negedge clk);
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL kill_out_valid got %0b want 0", seen); end
  endtask

  task automatic test_done_hold();
    logic [31:0] res;
    int          lat;
    issue(2'b00, 2'b00, 32'd1234, 32'd5678, 1'b0);
    wait_valid(res, lat);
    n_vec++;
    if (res !== 32'd7006652) begin n_err++; $display("FAIL hold_result got %h want %h", res, 32'd7006652); end
    for (int h = 0; h < 5; h++) begin
      n_vec++;
      if (result !== 32'd7006652 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d got res=%h valid=%0b ready=%0b want res=%h valid=1 ready=0",
                 h, result, out_valid, in_ready, 32'd7006652);
      end
      @(negedge clk);
    end
    take_result();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] res;
    int          lat;
    issue(2'b00, 2'b00, 32'd9, 32'd9, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL midreset got valid=%0b res=%h want valid=0 res=00000000", out_valid, result);
    end
    rst_n = 1'b1;
    issue(2'b00, 2'b00, 32'd6, 32'd7, 1'b0);
    wait_valid(res, lat);
    take_result();
    n_vec++;
    if (res !== 32'd42 || lat != 18) begin
      n_err++;
      $display("FAIL after_reset got res=%h lat=%0d want res=0000002a lat=18", res, lat);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    smode     = 2'b00;
    op_a      = '0;
    op_b      = '0;
    dit       = 1'b0;
    kill      = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_kill();
    test_done_hold();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
